mem_bus_router: RTL and testbench
=================================

MEM_BUS_ROUTER -- requirements
Module: mem_bus_router

Interface
REQ-001 Parameters SHALL be: NUM_REGIONS, default 4, number of slave regions (1..8); REGION_SHIFT, default 16, low bit of the region index field; TIMEOUT_CYCLES, default 15, maximum wait for a slave ack (1..255).
REQ-002 ADDR_W and DATA_W SHALL both be fixed at 32.
REQ-003 The design SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 m_req  input  1  master request strobe, sampled only when m_ready=1.
REQ-007 m_we  input  1  write enable; 1 = write, 0 = read.
REQ-008 m_addr  input  32  byte address.
REQ-009 m_wdata  input  32  write data.
REQ-010 m_ready  output  1  router idle and able to accept a request.
REQ-011 m_done  output  1  one-cycle completion pulse.
REQ-012 m_error  output  1  qualifies m_done as an error completion.
REQ-013 m_rdata  output  32  read data, valid while m_done=1 and m_error=0.
REQ-014 s_sel  output  NUM_REGIONS  one-hot slave select.
REQ-015 s_we, s_addr, s_wdata  output  1/32/32  latched copies of the request, forwarded to all slaves.
REQ-016 s_rdata  input  NUM_REGIONS*32  flattened slave read data; slice i is bits [32i+31:32i].
REQ-017 s_ack  input  NUM_REGIONS  per-slave completion.
REQ-018 err_count  output  8  saturating count of error completions.
REQ-019 last_err_addr  output  32  address of the most recent error completion.

Function
REQ-020 Region index SHALL be idx = m_addr[31:REGION_SHIFT]; the request is mapped iff idx < NUM_REGIONS.
REQ-021 The FSM SHALL have four states: IDLE, ACCESS, RESP and ERROR.
REQ-022 m_ready SHALL equal 1 only in IDLE.
REQ-023 IDLE with m_req=1: the router SHALL latch m_we, m_addr, m_wdata and idx, then go to ACCESS if mapped, else to ERROR.
REQ-024 ACCESS: s_sel[idx] SHALL be 1 and all other s_sel bits 0; the timeout counter SHALL clear on entry and increment each cycle.
REQ-025 ACCESS with s_ack[idx]=1: the router SHALL capture slice idx of s_rdata into m_rdata and go to RESP.
REQ-026 s_ack bits other than idx SHALL be ignored in every state.
REQ-027 ACCESS with no ack and the counter equal to TIMEOUT_CYCLES-1: the router SHALL go to ERROR.
REQ-028 If the ack and the timeout coincide, the ack SHALL win.
REQ-029 RESP SHALL last one cycle: m_done=1, m_error=0, then IDLE.
REQ-030 ERROR SHALL last one cycle: m_done=1, m_error=1, m_rdata=0, err_count += 1 (saturating at 255), last_err_addr = latched address, then IDLE.
REQ-031 Latency: a mapped access acked on the first ACCESS cycle SHALL give m_done 2 cycles after acceptance; an unmapped access SHALL give m_done 1 cycle after acceptance.
REQ-032 A timed-out access SHALL give m_done TIMEOUT_CYCLES+1 cycles after acceptance.
REQ-033 s_sel SHALL be all zero in IDLE, RESP and ERROR, so back-to-back requests always have at least one deselected cycle between them.
REQ-034 m_req while m_ready=0 SHALL be ignored and not queued.
REQ-035 s_addr, s_we and s_wdata SHALL hold stable from ACCESS entry until the return to IDLE.

Reset
REQ-036 With rst_n=0 at a clock edge, the router SHALL enter IDLE, m_ready=1, and clear m_done, m_error, m_rdata, s_sel, s_we, s_addr, s_wdata, err_count, last_err_addr and the timeout counter.
REQ-037 Reset during ACCESS SHALL drop s_sel on the same edge, and no m_done SHALL be issued for the aborted request.

Verification
REQ-038 Mapped read: m_addr=0x0001_0010, s_ack[1] first ACCESS cycle, s_rdata slice 1 = 0xDEADBEEF -> s_sel=4'b0010 for 1 cycle, m_done=1 with m_rdata=0xDEADBEEF 2 cycles after accept.
REQ-039 Unmapped: m_addr=0x0007_0000 -> no s_sel, m_done=1, m_error=1 next cycle, err_count=1, last_err_addr=0x0007_0000.
REQ-040 Timeout: m_addr=0x0002_0000 with no ack -> s_sel=4'b0100 for 15 cycles, then m_done=1, m_error=1, err_count increments.
REQ-041 Stray and coincident acks: s_ack[3] pulsed while idx=0 -> ignored; s_ack[0] arriving on counter=14 -> normal RESP with no error.
REQ-042 Saturation and reset: 260 unmapped requests -> err_count=255; rst_n=0 mid-ACCESS -> s_sel=0 next edge, no m_done, all outputs cleared.

Source files
------------

// File: rtl/mem_bus_router.sv
// mem_bus_router
//   Routes single master accesses to one of NUM_REGIONS slave regions chosen
//   by the address field m_addr[31:REGION_SHIFT]. Unmapped addresses and
//   slaves that fail to ack within TIMEOUT_CYCLES complete with an error.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   m_req/m_we/m_addr/m_wdata  master request (sampled only while m_ready=1)
//   m_ready                    router idle
//   m_done/m_error/m_rdata     one-cycle completion, error flag, read data
//   s_sel/s_we/s_addr/s_wdata  one-hot slave select and latched request
//   s_rdata/s_ack              flattened slave read data and per-slave ack
//   err_count/last_err_addr    saturating error count, last error address
//
// state  | meaning
// IDLE   | ready, waiting for m_req
// ACCESS | selected slave driven, waiting for its ack or the timeout
// RESP   | one-cycle successful completion
// ERROR  | one-cycle error completion (unmapped or timed out)

module mem_bus_router #(
    parameter int NUM_REGIONS    = 4,
    parameter int REGION_SHIFT   = 16,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      m_req,
    input  logic                      m_we,
    input  logic [31:0]               m_addr,
    input  logic [31:0]               m_wdata,
    output logic                      m_ready,
    output logic                      m_done,
    output logic                      m_error,
    output logic [31:0]               m_rdata,
    output logic [NUM_REGIONS-1:0]    s_sel,
    output logic                      s_we,
    output logic [31:0]               s_addr,
    output logic [31:0]               s_wdata,
    input  logic [NUM_REGIONS*32-1:0] s_rdata,
    input  logic [NUM_REGIONS-1:0]    s_ack,
    output logic [7:0]                err_count,
    output logic [31:0]               last_err_addr
);

    localparam int          SEL_W   = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam logic [31:0] NUM_R32 = 32'(NUM_REGIONS);
    localparam logic [7:0]  TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2,
        ST_ERROR  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d;
    logic [31:0]       addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [SEL_W-1:0]  idx_q, idx_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [7:0]        err_cnt_q, err_cnt_d;
    logic [31:0]       last_err_q, last_err_d;

    logic [31:0]            idx_full;
    logic                   mapped;
    logic                   ack_hit;
    logic [31:0]            slv_rdata;
    logic [NUM_REGIONS-1:0] sel_vec;
    logic [7:0]             err_inc;

    assign idx_full = m_addr >> REGION_SHIFT;
    assign mapped   = (idx_full < NUM_R32);
    assign err_inc  = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;

    // Mux the latched region's ack and read data; acks from other regions
    // never reach the FSM.
    always_comb begin
        ack_hit   = 1'b0;
        slv_rdata = '0;
        sel_vec   = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (idx_q == SEL_W'(i)) begin
                ack_hit    = s_ack[i];
                slv_rdata  = s_rdata[i*32 +: 32];
                sel_vec[i] = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        rdata_d    = rdata_q;
        err_cnt_d  = err_cnt_q;
        last_err_d = last_err_q;

        case (state_q)
            ST_IDLE: begin
                if (m_req) begin
                    we_d    = m_we;
                    addr_d  = m_addr;
                    wdata_d = m_wdata;
                    idx_d   = idx_full[SEL_W-1:0];
                    cnt_d   = 8'd0;
                    if (mapped) begin
                        state_d = ST_ACCESS;
                    end else begin
                        // Error bookkeeping is done on entry so it is already
                        // visible while m_done/m_error are high.
                        state_d    = ST_ERROR;
                        err_cnt_d  = err_inc;
                        last_err_d = m_addr;
                    end
                end
            end
            ST_ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (ack_hit) begin
                    rdata_d = slv_rdata;
                    state_d = ST_RESP;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = ST_ERROR;
                    err_cnt_d  = err_inc;
                    last_err_d = addr_q;
                end
            end
            ST_RESP:  state_d = ST_IDLE;
            ST_ERROR: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            rdata_q    <= '0;
            err_cnt_q  <= '0;
            last_err_q <= '0;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            rdata_q    <= rdata_d;
            err_cnt_q  <= err_cnt_d;
            last_err_q <= last_err_d;
        end
    end

    assign m_ready       = (state_q == ST_IDLE);
    assign m_done        = (state_q == ST_RESP) || (state_q == ST_ERROR);
    assign m_error       = (state_q == ST_ERROR);
    assign m_rdata       = (state_q == ST_RESP) ? rdata_q : 32'd0;
    assign s_sel         = (state_q == ST_ACCESS) ? sel_vec : '0;
    assign s_we          = we_q;
    assign s_addr        = addr_q;
    assign s_wdata       = wdata_q;
    assign err_count     = err_cnt_q;
    assign last_err_addr = last_err_q;

endmodule

// File: tb/tb_mem_bus_router.sv
module tb_mem_bus_router;

    localparam int NR = 4;
    localparam int RS = 16;
    localparam int TO = 15;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              m_req, m_we;
    logic [31:0]       m_addr, m_wdata;
    logic              m_ready, m_done, m_error;
    logic [31:0]       m_rdata;
    logic [NR-1:0]     s_sel;
    logic              s_we;
    logic [31:0]       s_addr, s_wdata;
    logic [NR*32-1:0]  s_rdata;
    logic [NR-1:0]     s_ack;
    logic [7:0]        err_count;
    logic [31:0]       last_err_addr;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: error count and last error address as the spec defines them.
    int          exp_err_cnt  = 0;
    logic [31:0] exp_last_err = 32'd0;
    logic [31:0] slv_data [NR];

    always #5 clk = ~clk;

    mem_bus_router #(
        .NUM_REGIONS   (NR),
        .REGION_SHIFT  (RS),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .m_req        (m_req),
        .m_we         (m_we),
        .m_addr       (m_addr),
        .m_wdata      (m_wdata),
        .m_ready      (m_ready),
        .m_done       (m_done),
        .m_error      (m_error),
        .m_rdata      (m_rdata),
        .s_sel        (s_sel),
        .s_we         (s_we),
        .s_addr       (s_addr),
        .s_wdata      (s_wdata),
        .s_rdata      (s_rdata),
        .s_ack        (s_ack),
        .err_count    (err_count),
        .last_err_addr(last_err_addr)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One master transaction. ack_delay = ACCESS cycle (0-based) on which the
    // selected slave acks; values >= TO mean the slave never acks. noisy
    // drives stray acks on other slaves and junk master requests while busy.
    task automatic run_txn(input logic [31:0] addr, input logic we, input logic [31:0] wdata,
                           input int ack_delay, input bit noisy,
                           input bit force_en, input logic [31:0] force_data);
        int          idx;
        bit          mapped;
        int          done_cyc;
        bit          exp_err;
        logic [31:0] exp_rdata;
        logic [NR-1:0] exp_sel;
        logic [NR-1:0] ack;
        @(negedge clk);
        for (int w = 0; w < 50 && m_ready !== 1'b1; w++) @(negedge clk);
        n_tests++;
        if (m_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_wait: m_ready=%b required 1", m_ready);
            return;
        end
        idx    = int'(addr >> RS);
        mapped = (idx < NR);
        if (mapped && ack_delay < TO) begin
            done_cyc = ack_delay + 2; exp_err = 1'b0;
        end else if (mapped) begin
            done_cyc = TO + 1; exp_err = 1'b1;
        end else begin
            done_cyc = 1; exp_err = 1'b1;
        end
        exp_sel   = mapped ? (NR'(1) << idx) : '0;
        exp_rdata = 32'd0;
        m_req = 1'b1; m_we = we; m_addr = addr; m_wdata = wdata; s_ack = '0;
        for (int k = 1; k <= done_cyc; k++) begin
            @(negedge clk);
            if (noisy && k < done_cyc) begin
                m_req = 1'($urandom); m_we = 1'($urandom);
                m_addr = $urandom; m_wdata = $urandom;
            end else begin
                m_req = 1'b0;
            end
            if (k < done_cyc) begin
                n_tests++;
                if (m_done !== 1'b0 || m_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL busy_flags addr=%h cyc=%0d: m_done=%b m_ready=%b required 0/0", addr, k, m_done, m_ready);
                end
                n_tests++;
                if (s_sel !== exp_sel) begin
                    n_fail++;
                    $display("FAIL s_sel addr=%h cyc=%0d: got %b required %b", addr, k, s_sel, exp_sel);
                end
                n_tests++;
                if (s_addr !== addr || s_we !== we || s_wdata !== wdata) begin
                    n_fail++;
                    $display("FAIL s_fwd addr=%h cyc=%0d: got %h/%b/%h required %h/%b/%h",
                             addr, k, s_addr, s_we, s_wdata, addr, we, wdata);
                end
                for (int i = 0; i < NR; i++) begin
                    slv_data[i] = $urandom;
                    s_rdata[i*32 +: 32] = slv_data[i];
                end
                ack = noisy ? NR'($urandom) : '0;
                if (mapped) begin
                    ack = ack & ~exp_sel;
                    if (k - 1 == ack_delay) begin
                        ack = ack | exp_sel;
                        if (force_en) begin
                            slv_data[idx] = force_data;
                            s_rdata[idx*32 +: 32] = force_data;
                        end
                        exp_rdata = slv_data[idx];
                    end
                end
                s_ack = ack;
            end else begin
                s_ack = '0;
                if (exp_err) begin
                    exp_err_cnt  = (exp_err_cnt < 255) ? exp_err_cnt + 1 : 255;
                    exp_last_err = addr;
                end
                n_tests++;
                if (m_done !== 1'b1 || m_error !== exp_err) begin
                    n_fail++;
                    $display("FAIL done addr=%h cyc=%0d: m_done=%b m_error=%b required 1/%b", addr, k, m_done, m_error, exp_err);
                end
                n_tests++;
                if (m_rdata !== exp_rdata) begin
                    n_fail++;
                    $display("FAIL m_rdata addr=%h: got %h required %h", addr, m_rdata, exp_rdata);
                end
                n_tests++;
                if (s_sel !== '0) begin
                    n_fail++;
                    $display("FAIL s_sel_done addr=%h: got %b required 0", addr, s_sel);
                end
                n_tests++;
                if (err_count !== 8'(exp_err_cnt) || last_err_addr !== exp_last_err) begin
                    n_fail++;
                    $display("FAIL err_info addr=%h: got %0d/%h required %0d/%h",
                             addr, err_count, last_err_addr, exp_err_cnt, exp_last_err);
                end
            end
        end
        @(negedge clk);
        n_tests++;
        if (m_ready !== 1'b1 || m_done !== 1'b0 || s_sel !== '0) begin
            n_fail++;
            $display("FAIL return_idle addr=%h: m_ready=%b m_done=%b s_sel=%b required 1/0/0", addr, m_ready, m_done, s_sel);
        end
    endtask

    task automatic test_reset;
        n_tests++;
        if (m_ready !== 1'b1 || m_done !== 1'b0 || m_error !== 1'b0 || m_rdata !== 32'd0 ||
            s_sel !== '0 || s_we !== 1'b0 || s_addr !== 32'd0 || s_wdata !== 32'd0 ||
            err_count !== 8'd0 || last_err_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b done=%b err=%b rdata=%h sel=%b we=%b addr=%h wd=%h cnt=%0d last=%h",
                     m_ready, m_done, m_error, m_rdata, s_sel, s_we, s_addr, s_wdata, err_count, last_err_addr);
        end
    endtask

    task automatic test_mapped_read;
        run_txn(32'h0001_0010, 1'b0, 32'h0, 0, 1'b0, 1'b1, 32'hDEAD_BEEF);
        run_txn(32'h0003_FFFC, 1'b1, 32'h1234_5678, 2, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic test_unmapped;
        run_txn(32'h0007_0000, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0);
        run_txn(32'hFFFF_0004, 1'b1, 32'hCAFE_0001, 0, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_timeout;
        run_txn(32'h0002_0000, 1'b0, 32'h0, 99, 1'b0, 1'b0, 32'h0);
        run_txn(32'h0000_0100, 1'b1, 32'h5555_AAAA, TO, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_stray_and_coincident;
        run_txn(32'h0000_0008, 1'b0, 32'h0, 4, 1'b1, 1'b0, 32'h0);
        run_txn(32'h0000_0040, 1'b0, 32'h0, TO - 1, 1'b1, 1'b0, 32'h0);
        run_txn(32'h0001_0000, 1'b0, 32'h0, TO - 2, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic test_random;
        logic [31:0] a;
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[31:RS] = 16'($urandom_range(0, NR + 1));
            run_txn(a, 1'($urandom), $urandom, $urandom_range(0, TO + 2), 1'($urandom), 1'b0, 32'h0);
        end
    endtask

    task automatic test_saturation;
        logic [31:0] a;
        for (int n = 0; n < 260; n++) begin
            a = $urandom;
            a[31:RS] = 16'($urandom_range(NR, 16'hFFFF));
            run_txn(a, 1'b0, 32'h0, 0, 1'b0, 1'b0, 32'h0);
        end
        n_tests++;
        if (err_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: err_count=%0d required 255", err_count);
        end
    endtask

    task automatic test_reset_mid_access;
        bit saw_done;
        @(negedge clk);
        m_req = 1'b1; m_we = 1'b1; m_addr = 32'h0003_0020; m_wdata = 32'hA5A5_5A5A; s_ack = '0;
        @(negedge clk);
        m_req = 1'b0;
        n_tests++;
        if (s_sel !== 4'b1000) begin
            n_fail++;
            $display("FAIL pre_reset_sel: got %b required 1000", s_sel);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_err_cnt  = 0;
        exp_last_err = 32'd0;
        n_tests++;
        if (s_sel !== '0 || m_ready !== 1'b1 || m_done !== 1'b0 || m_error !== 1'b0 ||
            m_rdata !== 32'd0 || s_addr !== 32'd0 || s_we !== 1'b0 || s_wdata !== 32'd0 ||
            err_count !== 8'd0 || last_err_addr !== 32'd0) begin
            n_fail++;
            $display("FAIL mid_reset: sel=%b rdy=%b done=%b err=%b addr=%h cnt=%0d last=%h",
                     s_sel, m_ready, m_done, m_error, s_addr, err_count, last_err_addr);
        end
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int k = 0; k < TO + 4; k++) begin
            @(negedge clk);
            if (m_done !== 1'b0) saw_done = 1'b1;
        end
        n_tests++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL aborted_done: m_done seen after reset, required none");
        end
        run_txn(32'h0000_0004, 1'b0, 32'h0, 1, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; m_req = 1'b0; m_we = 1'b0; m_addr = '0; m_wdata = '0;
        s_rdata = '0; s_ack = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst_n = 1'b1;
        test_mapped_read;
        test_unmapped;
        test_timeout;
        test_stray_and_coincident;
        test_random;
        test_saturation;
        test_reset_mid_access;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
